// File: rtl/register_if_id.sv
// IF/ID pipeline register: captures the Fetch-stage PC, PC+4 and instruction for Decode.
// Synchronous reset, then flush (bubble), then stall (hold), then load.
module register_if_id #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  FLUSH_INSTR = 32'h00000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic [XLEN-1:0] RD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic [XLEN-1:0] InstrD
);

    // Reset and flush both leave a bubble; flush wins over a simultaneous stall.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            PCD      <= '0;
            PCPlus4D <= '0;
            InstrD   <= FLUSH_INSTR;
        end else if (!StallD) begin
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            InstrD   <= RD;
        end
    end

endmodule

// File: tb/tb_register_if_id.sv
// Self-checking bench for register_if_id: directed scenarios plus randomized
// control/data traffic against a rule-level reference model.
module tb_register_if_id;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] FLUSH_INSTR = 32'h00000000;

    // Clock / reset block
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            StallD = 1'b0;
    logic            FlushD = 1'b0;
    logic [XLEN-1:0] PCF = '0;
    logic [XLEN-1:0] PCPlus4F = '0;
    logic [XLEN-1:0] RD = '0;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [XLEN-1:0] InstrD;

    always #5 clk = ~clk;

    register_if_id #(.XLEN(XLEN), .FLUSH_INSTR(FLUSH_INSTR)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .RD(RD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD)
    );

    // Scoreboard
    int errors = 0;
    int checks = 0;
    logic [3*XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] m_pc, m_pc4, m_instr;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: what the Decode stage must see after an edge with these inputs.
    task automatic model_edge(input logic r, input logic f, input logic s,
                              input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pc4,
                              input logic [XLEN-1:0] ins);
        if (r || f) begin
            m_pc = '0; m_pc4 = '0; m_instr = FLUSH_INSTR;
        end else if (!s) begin
            m_pc = pc; m_pc4 = pc4; m_instr = ins;
        end
        exp_q.push_back({m_pc, m_pc4, m_instr});
    endtask

    task automatic check_outputs(input string tag);
        logic [3*XLEN-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pcd"},    PCD,      e[3*XLEN-1:2*XLEN]);
            check({tag, "_pc4d"},   PCPlus4D, e[2*XLEN-1:XLEN]);
            check({tag, "_instrd"}, InstrD,   e[XLEN-1:0]);
        end
    endtask

    // Outputs must equal the model's current state (no edge in between).
    task automatic check_hold(input string tag);
        check({tag, "_pcd"},    PCD,      m_pc);
        check({tag, "_pc4d"},   PCPlus4D, m_pc4);
        check({tag, "_instrd"}, InstrD,   m_instr);
    endtask

    // Driver: apply inputs away from the edge, clock once, check after the edge.
    task automatic step(input string tag, input logic r, input logic f, input logic s,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pc4,
                        input logic [XLEN-1:0] ins);
        @(negedge clk);
        reset = r; FlushD = f; StallD = s; PCF = pc; PCPlus4F = pc4; RD = ins;
        @(posedge clk);
        model_edge(r, f, s, pc, pc4, ins);
        #1;
        check_outputs(tag);
    endtask

    // Inputs (and reset) wiggle between edges; only the value at the edge counts.
    task automatic step_toggle(input string tag, input logic [XLEN-1:0] pc_a,
                               input logic [XLEN-1:0] ins_a, input logic [XLEN-1:0] pc_b,
                               input logic [XLEN-1:0] ins_b);
        @(negedge clk);
        reset = 1'b1; FlushD = 1'b1; StallD = 1'b0;
        PCF = pc_a; PCPlus4F = pc_a + 4; RD = ins_a;
        #1;
        check_hold({tag, "_mid_a"});
        reset = 1'b0; FlushD = 1'b0;
        PCF = pc_b; PCPlus4F = pc_b + 4; RD = ins_b;
        #1;
        check_hold({tag, "_mid_b"});
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, pc_b, pc_b + 4, ins_b);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        m_pc = '0; m_pc4 = '0; m_instr = FLUSH_INSTR;

        // Reset with live data on the inputs
        step("reset", 1, 0, 0, 32'h0, 32'h4, 32'hAABBCCDD);
        step("reset2", 1, 0, 1, 32'h5, 32'h9, 32'h12345678);

        // Back-to-back loads
        step("load1", 0, 0, 0, 32'h10000000, 32'h10000004, 32'h11112222);
        step("load2", 0, 0, 0, 32'h10000004, 32'h10000008, 32'h33334444);

        // Stall holds, release loads
        step("stall1", 0, 0, 1, 32'h20000000, 32'h20000004, 32'hDEADBEEF);
        step("stall2", 0, 0, 1, 32'h20000000, 32'h20000004, 32'hDEADBEEF);
        step("unstall", 0, 0, 0, 32'h20000000, 32'h20000004, 32'hDEADBEEF);

        // Flush for one edge, then normal load
        step("flush", 0, 1, 0, 32'hCAFE0000, 32'hCAFE0004, 32'hFFFFFFFF);
        step("post_flush", 0, 0, 0, 32'h12345678, 32'h1234567C, 32'h87654321);

        // Flush beats stall; reset beats stall
        step("flush_stall", 0, 1, 1, 32'h0BAD0000, 32'h0BAD0004, 32'h0BADF00D);
        step("load3", 0, 0, 0, 32'h30000000, 32'h30000004, 32'h55556666);
        step("reset_stall", 1, 0, 1, 32'h40000000, 32'h40000004, 32'h77778888);
        step("after_reset", 0, 0, 1, 32'h50000000, 32'h50000004, 32'h9999AAAA);
        step("after_reset_load", 0, 0, 0, 32'h50000000, 32'h50000004, 32'h9999AAAA);

        // Stall then reset mid-stall
        step("stall3", 0, 0, 1, 32'h60000000, 32'h60000004, 32'hBBBBCCCC);
        step("reset_in_stall", 1, 0, 1, 32'h60000000, 32'h60000004, 32'hBBBBCCCC);

        // Between-edge toggling
        step_toggle("toggle1", 32'hA0000000, 32'h01010101, 32'hB0000000, 32'h02020202);
        step_toggle("toggle2", 32'hC0000000, 32'h03030303, 32'hD0000000, 32'h04040404);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_if_id.md
REGISTER_IF_ID -- requirements
Module: register_if_id

Interface
REQ-001 Parameter: XLEN, default 32, width of every data port.
REQ-002 Parameter: FLUSH_INSTR, default 32'h00000000, value loaded into InstrD on reset or flush.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled only at the rising clk edge.
REQ-005 Port: StallD  input  1  active-high hold request for the Decode stage.
REQ-006 Port: FlushD  input  1  active-high bubble insertion for the Decode stage.
REQ-007 Port: PCF  input  XLEN  Fetch-stage program counter.
REQ-008 Port: PCPlus4F  input  XLEN  Fetch-stage PC+4.
REQ-009 Port: RD  input  XLEN  instruction word read from instruction memory in Fetch.
REQ-010 Port: PCD  output  XLEN  registered PC for Decode.
REQ-011 Port: PCPlus4D  output  XLEN  registered PC+4 for Decode.
REQ-012 Port: InstrD  output  XLEN  registered instruction for Decode.

Function
REQ-013 All three outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-014 Each rising clk edge SHALL apply exactly one action, in priority order: reset, then FlushD, then StallD, then load.
REQ-015 Load (reset=0, FlushD=0, StallD=0): PCD<=PCF, PCPlus4D<=PCPlus4F, InstrD<=RD, visible one cycle after sampling (latency 1).
REQ-016 Stall (reset=0, FlushD=0, StallD=1): all three registers SHALL hold their current values; inputs are ignored.
REQ-017 Flush (reset=0, FlushD=1): PCD<=0, PCPlus4D<=0, InstrD<=FLUSH_INSTR, regardless of StallD.
REQ-018 Simultaneous FlushD=1 and StallD=1 SHALL flush (REQ-017).
REQ-019 The flush and reset actions last one edge only; the edge after FlushD returns to 0 SHALL load or stall normally.
REQ-020 Input changes between clock edges SHALL not affect outputs until the next rising edge.
REQ-021 The block SHALL contain no other state, counters or handshake; StallD and FlushD are level-sensitive per edge.

Reset
REQ-022 reset=1 at a rising edge SHALL set PCD=0, PCPlus4D=0, InstrD=FLUSH_INSTR, overriding FlushD, StallD and all data inputs.
REQ-023 Reset SHALL be synchronous only; asserting reset between edges SHALL not change outputs before the next rising edge.
REQ-024 Reset asserted mid-operation, including during a stall, SHALL clear at the next edge; the first edge with reset=0 SHALL behave per REQ-014.
REQ-025 Outputs before the first rising edge are undefined; the bench SHALL hold reset high for at least one edge.

Verification
REQ-026 reset=1 with PCF=0, PCPlus4F=4, RD=AABBCCDD for one edge -> PCD=0, PCPlus4D=0, InstrD=0.
REQ-027 reset=0, load PCF=10000000, PCPlus4F=10000004, RD=11112222, then 10000004/10000008/33334444 on consecutive edges -> outputs follow with one-cycle latency.
REQ-028 StallD=1 with inputs 20000000/20000004/DEADBEEF -> outputs hold 10000004/10000008/33334444; after StallD=0, the next edge loads 20000000/20000004/DEADBEEF.
REQ-029 FlushD=1 for one edge -> outputs 0/0/0; with FlushD=0 and inputs 12345678/1234567C/87654321, the next edge -> PCD=12345678, PCPlus4D=1234567C, InstrD=87654321.
REQ-030 FlushD=1 and StallD=1 together -> outputs 0/0/0; reset=1 together with FlushD=0 and StallD=1 -> outputs 0/0/0.
REQ-031 Toggle PCF and RD between edges while StallD=0 -> outputs change only at rising edges and take the value present at the edge.
